// File: rtl/watch_set_ctrl_pkg.sv
// Shared types and constants for the watch time-setting editor.
// Field layout of the packed load word and the editor state encoding.
package watch_set_ctrl_pkg;

  localparam int HW = 5;
  localparam int MW = 6;
  localparam int BW = 17;

  localparam int HOUR_LSB = 12;
  localparam int MIN_LSB  = 6;
  localparam int SEC_LSB  = 0;

  localparam int HOUR_MAX_DEF = 23;
  localparam int MS_MAX_DEF   = 59;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EDIT_HOUR,
    ST_EDIT_MIN,
    ST_EDIT_SEC,
    ST_COMMIT
  } state_e;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_HOUR = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;
  localparam logic [1:0] FLD_SEC  = 2'd3;

endpackage

// File: rtl/watch_set_ctrl_if.sv
// Button, running-time and load/status bundle of the set editor.
// master drives buttons and time; slave is the editor.
interface watch_set_ctrl_if;
  import watch_set_ctrl_pkg::*;

  logic          en_1hz;
  logic          btn_mode;
  logic          btn_next;
  logic          btn_up;
  logic          btn_down;
  logic [HW-1:0] cur_hour;
  logic [MW-1:0] cur_min;
  logic [MW-1:0] cur_sec;
  logic          set_watch;
  logic [BW-1:0] bin_watch;
  logic          editing;
  logic [1:0]    edit_field;

  modport master (
    output en_1hz, btn_mode, btn_next,
    output btn_up, btn_down,
    output cur_hour, cur_min, cur_sec,
    input  set_watch, bin_watch,
    input  editing, edit_field
  );

  modport slave (
    input  en_1hz, btn_mode, btn_next,
    input  btn_up, btn_down,
    input  cur_hour, cur_min, cur_sec,
    output set_watch, bin_watch,
    output editing, edit_field
  );

endinterface

// File: rtl/watch_set_ctrl_wrap_updown.sv
// Up/down step of one time field with wrap between 0 and MAX.
// Simultaneous up and down cancel out.
module wrap_updown #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic [W-1:0] val_i,
  input  logic         up_i,
  input  logic         down_i,
  output logic [W-1:0] nxt_o
);

  always_comb begin
    nxt_o = val_i;
    if (up_i && !down_i)
      nxt_o = (val_i == W'(MAX)) ? '0 : val_i + 1'b1;
    else if (down_i && !up_i)
      nxt_o = (val_i == '0) ? W'(MAX) : val_i - 1'b1;
  end

endmodule

// File: rtl/watch_set_ctrl.sv
// Time-setting editor: captures running time, edits it field by
// field and commits it to the watch counter with a one-cycle load.
module watch_set_ctrl
  import watch_set_ctrl_pkg::*;
#(
  parameter int TIMEOUT_S = 30,
  parameter int HOUR_MAX  = HOUR_MAX_DEF,
  parameter int MS_MAX    = MS_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  watch_set_ctrl_if.slave wif
);

  localparam int TW = $clog2(TIMEOUT_S + 1);

  state_e        state_q, state_d;
  logic [HW-1:0] hour_q, hour_d, hour_nx;
  logic [MW-1:0] min_q, min_d, min_nx;
  logic [MW-1:0] sec_q, sec_d, sec_nx;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          any_btn;
  logic          sel_h, sel_m, sel_s;
  logic [BW-1:0] bin_w;

  assign any_btn = wif.btn_mode | wif.btn_next
                 | wif.btn_up | wif.btn_down;

  assign sel_h = (state_q == ST_EDIT_HOUR);
  assign sel_m = (state_q == ST_EDIT_MIN);
  assign sel_s = (state_q == ST_EDIT_SEC);

  wrap_updown #(.W(HW), .MAX(HOUR_MAX)) u_hour (
    .val_i  (hour_q),
    .up_i   (wif.btn_up & sel_h),
    .down_i (wif.btn_down & sel_h),
    .nxt_o  (hour_nx)
  );

  wrap_updown #(.W(MW), .MAX(MS_MAX)) u_min (
    .val_i  (min_q),
    .up_i   (wif.btn_up & sel_m),
    .down_i (wif.btn_down & sel_m),
    .nxt_o  (min_nx)
  );

  wrap_updown #(.W(MW), .MAX(MS_MAX)) u_sec (
    .val_i  (sec_q),
    .up_i   (wif.btn_up & sel_s),
    .down_i (wif.btn_down & sel_s),
    .nxt_o  (sec_nx)
  );

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wif.btn_mode) begin
          hour_d  = (wif.cur_hour > HW'(HOUR_MAX))
                  ? '0 : wif.cur_hour;
          min_d   = (wif.cur_min > MW'(MS_MAX))
                  ? '0 : wif.cur_min;
          sec_d   = (wif.cur_sec > MW'(MS_MAX))
                  ? '0 : wif.cur_sec;
          tmo_d   = '0;
          state_d = ST_EDIT_HOUR;
        end
      end
      ST_EDIT_HOUR, ST_EDIT_MIN, ST_EDIT_SEC: begin
        // a button in the same cycle as a tick wins
        if (any_btn)
          tmo_d = '0;
        else if (wif.en_1hz)
          tmo_d = tmo_q + 1'b1;
        if (wif.btn_mode) begin
          state_d = ST_COMMIT;
        end else if (wif.btn_next) begin
          state_d = sel_h ? ST_EDIT_MIN
                  : sel_m ? ST_EDIT_SEC
                  : ST_EDIT_HOUR;
        end else if (any_btn) begin
          hour_d = hour_nx;
          min_d  = min_nx;
          sec_d  = sec_nx;
        end else if (wif.en_1hz &&
                     tmo_q == TW'(TIMEOUT_S - 1)) begin
          tmo_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    bin_w = '0;
    bin_w[HOUR_LSB +: HW] = hour_q;
    bin_w[MIN_LSB  +: MW] = min_q;
    bin_w[SEC_LSB  +: MW] = sec_q;
  end

  always_comb begin
    wif.edit_field = FLD_NONE;
    unique case (state_q)
      ST_EDIT_HOUR: wif.edit_field = FLD_HOUR;
      ST_EDIT_MIN:  wif.edit_field = FLD_MIN;
      ST_EDIT_SEC:  wif.edit_field = FLD_SEC;
      default:      wif.edit_field = FLD_NONE;
    endcase
  end

  // reset in COMMIT must suppress the load in that same cycle
  assign wif.set_watch = (state_q == ST_COMMIT) & ~rst;
  assign wif.bin_watch = bin_w;
  assign wif.editing   = sel_h | sel_m | sel_s;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Scoreboard bench for watch_set_ctrl: commits are queued when
// btn_mode is pressed and matched when set_watch fires.
module tb_watch_set_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [16:0] exp_q[$];
  logic prev_sw = 1'b0;

  watch_set_ctrl_if w ();

  watch_set_ctrl #(.TIMEOUT_S(3)) dut (
    .clk (clk),
    .rst (rst),
    .wif (w)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] pk(input int h,
                                     input int m,
                                     input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  always @(negedge clk) begin
    if (w.set_watch) begin
      check("sw_double", 32'(prev_sw), 0);
      if (exp_q.size() == 0)
        check("sw_unexpected", 32'(w.set_watch), 0);
      else
        check("bin_watch", 32'(w.bin_watch),
              32'(exp_q.pop_front()));
    end
    prev_sw = w.set_watch;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic btn(input logic m, input logic n,
                     input logic u, input logic d,
                     input logic t);
    w.btn_mode = m;
    w.btn_next = n;
    w.btn_up   = u;
    w.btn_down = d;
    w.en_1hz   = t;
    step();
    w.btn_mode = 1'b0;
    w.btn_next = 1'b0;
    w.btn_up   = 1'b0;
    w.btn_down = 1'b0;
    w.en_1hz   = 1'b0;
  endtask

  task automatic enter(input int h, input int m,
                       input int s);
    w.cur_hour = 5'(h);
    w.cur_min  = 6'(m);
    w.cur_sec  = 6'(s);
    btn(1, 0, 0, 0, 0);
  endtask

  task automatic commit(input logic [16:0] e);
    exp_q.push_back(e);
    btn(1, 0, 0, 0, 0);
    step();
    check("idle_after_commit", 32'(w.editing), 0);
    check("sb_drain", exp_q.size(), 0);
  endtask

  initial begin
    w.btn_mode = 0; w.btn_next = 0;
    w.btn_up = 0;   w.btn_down = 0;
    w.en_1hz = 0;
    w.cur_hour = 0; w.cur_min = 0; w.cur_sec = 0;
    step();
    step();
    check("rst_set_watch", 32'(w.set_watch), 0);
    check("rst_bin", 32'(w.bin_watch), 0);
    check("rst_editing", 32'(w.editing), 0);
    check("rst_field", 32'(w.edit_field), 0);
    rst = 1'b0;

    // idle ignores non-mode buttons
    btn(0, 1, 1, 1, 1);
    check("idle_ignore", 32'(w.editing), 0);

    enter(10, 20, 30);
    check("enter_editing", 32'(w.editing), 1);
    check("enter_field", 32'(w.edit_field), 1);
    repeat (3) btn(0, 0, 1, 0, 0);
    check("edit_still", 32'(w.edit_field), 1);
    commit(pk(13, 20, 30));

    enter(23, 0, 59);
    btn(0, 0, 1, 0, 0);
    check("hour_wrap", 32'(w.bin_watch), 32'(pk(0, 0, 59)));
    btn(0, 1, 0, 0, 0);
    check("field_min", 32'(w.edit_field), 2);
    btn(0, 0, 0, 1, 0);
    check("min_wrap", 32'(w.bin_watch), 32'(pk(0, 59, 59)));
    btn(0, 1, 0, 0, 0);
    check("field_sec", 32'(w.edit_field), 3);
    btn(0, 0, 1, 0, 0);
    btn(0, 1, 0, 0, 0);
    check("field_back_hour", 32'(w.edit_field), 1);
    commit(pk(0, 59, 0));

    enter(5, 6, 7);
    exp_q.push_back(pk(5, 6, 7));
    btn(1, 0, 1, 0, 0);
    step();
    check("prio_idle", 32'(w.editing), 0);
    check("prio_drain", exp_q.size(), 0);

    enter(8, 9, 10);
    btn(0, 0, 1, 1, 0);
    check("updown_hold", 32'(w.bin_watch), 32'(pk(8, 9, 10)));
    commit(pk(8, 9, 10));

    enter(1, 2, 3);
    btn(0, 0, 0, 0, 1);
    btn(0, 0, 0, 0, 1);
    check("tmo_two", 32'(w.editing), 1);
    btn(0, 0, 0, 0, 1);
    check("tmo_idle", 32'(w.editing), 0);
    check("tmo_field", 32'(w.edit_field), 0);

    enter(1, 2, 3);
    btn(0, 0, 0, 0, 1);
    btn(0, 0, 0, 0, 1);
    btn(0, 1, 0, 0, 1);
    btn(0, 0, 0, 0, 1);
    btn(0, 0, 0, 0, 1);
    check("tmo_restart", 32'(w.edit_field), 2);
    btn(0, 0, 0, 0, 1);
    check("tmo_restart_idle", 32'(w.editing), 0);

    enter(4, 5, 6);
    w.cur_hour = 7; w.cur_min = 8; w.cur_sec = 9;
    btn(0, 0, 0, 0, 1);
    btn(0, 0, 0, 0, 1);
    check("frozen", 32'(w.bin_watch), 32'(pk(4, 5, 6)));
    commit(pk(4, 5, 6));

    enter(2, 3, 4);
    btn(0, 1, 0, 0, 0);
    btn(0, 1, 0, 0, 0);
    check("pre_rst_field", 32'(w.edit_field), 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_edit_editing", 32'(w.editing), 0);
    check("rst_edit_field", 32'(w.edit_field), 0);
    check("rst_edit_bin", 32'(w.bin_watch), 0);
    check("rst_edit_sw", 32'(w.set_watch), 0);

    enter(2, 3, 4);
    btn(1, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("rst_commit_idle", 32'(w.editing), 0);

    enter(24, 62, 59);
    check("clamp", 32'(w.bin_watch), 32'(pk(0, 0, 59)));
    commit(pk(0, 0, 59));

    repeat (3) step();
    check("sb_final", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/watch_set_ctrl.md
Name: watch_set_ctrl

Overview:
- Time-setting editor that drives the watch counter's load interface (set_watch / bin_watch).
- Turns debounced single-cycle button pulses into an edit session:
  - captures the running time into a shadow register;
  - lets the user step through hour/min/sec fields and increment/decrement the selected field;
  - commits the result with a one-cycle load pulse.
- Sits between the button debouncers and the watch counter; also feeds the display with edit status.

Parameters:
- TIMEOUT_S, 30: seconds with no button activity in an edit state before the session aborts without committing.
- HOUR_MAX, 23: highest hour value; hour wraps HOUR_MAX<->0.
- MS_MAX, 59: highest minute/second value; min/sec wrap MS_MAX<->0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en_1hz  in  1  one-cycle tick per second
- btn_mode  in  1  debounced one-cycle pulse: enter edit / commit
- btn_next  in  1  debounced one-cycle pulse: advance selected field
- btn_up  in  1  debounced one-cycle pulse: increment selected field
- btn_down  in  1  debounced one-cycle pulse: decrement selected field
- cur_hour  in  5  running hour from watch counter
- cur_min  in  6  running minute
- cur_sec  in  6  running second
- set_watch  out  1  one-cycle load strobe to watch counter
- bin_watch  out  17  packed load value {hour[16:12], min[11:6], sec[5:0]}
- editing  out  1  high while in any EDIT_* state
- edit_field  out  2  0 = none, 1 = hour, 2 = min, 3 = sec

Behaviour:
- One clock domain. Reset is synchronous and active-high: sampled on posedge clk.
- Reset values:
  - state = IDLE; shadow hour/min/sec = 0; timeout counter = 0.
  - set_watch = 0; bin_watch = 0; editing = 0; edit_field = 0.
- bin_watch is always the registered shadow {h, m, s}. It is meaningful only while set_watch = 1.
- States: IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT.
- IDLE:
  - btn_mode: capture cur_* into the shadow, then go to EDIT_HOUR next cycle.
  - On capture, any out-of-range value (hour > HOUR_MAX, min/sec > MS_MAX) is loaded as 0.
  - All other buttons are ignored.
- EDIT_* priority when several pulses arrive in the same cycle: btn_mode > btn_next > btn_up/btn_down.
  - btn_mode: go to COMMIT.
  - btn_next: EDIT_HOUR -> EDIT_MIN -> EDIT_SEC -> EDIT_HOUR.
  - btn_up alone: selected field +1; wraps at its max to 0.
  - btn_down alone: selected field -1; wraps from 0 to its max.
  - btn_up and btn_down together: no change, but the timeout counter still clears.
  - Field arithmetic is done at field width. Non-selected fields hold.
- Shadow is frozen during edit: en_1hz does not advance it.
- COMMIT: lasts exactly one cycle.
  - set_watch = 1, bin_watch = shadow.
  - Next cycle: IDLE, set_watch = 0. Button pulses in COMMIT are ignored.
- Latency: btn_mode in an EDIT state at cycle N -> set_watch high at cycle N+1 -> IDLE at N+2.
- Timeout:
  - Counter clears on entering an EDIT state and on any button pulse.
  - It increments on en_1hz while in EDIT_*.
  - When it reaches TIMEOUT_S, go to IDLE with no set_watch. The shadow keeps its value; it is harmless.
  - A button pulse and en_1hz in the same cycle: the button wins and the counter clears.
- Outputs editing and edit_field are decoded from the registered state, so they have no glitches.
- Reset during an edit or in COMMIT: go to IDLE, no set_watch pulse that cycle or after.
- set_watch is never high for two consecutive cycles.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/EDIT_HOUR/EDIT_MIN/EDIT_SEC/COMMIT);
  - edit_field codes;
  - bin_watch field bit positions (HOUR_LSB = 12, MIN_LSB = 6, SEC_LSB = 0);
  - HOUR_MAX/MS_MAX defaults.
- One sub-module is natural: wrap_updown.
  - Parameterised width and max; inputs value, up, down; output next value with wrap.
  - Instantiated once per field.

Test Plan:
- Enter, edit, commit:
  - cur = 10:20:30; btn_mode, btn_up x3 -> editing = 1, edit_field = 1.
  - btn_mode -> one-cycle set_watch with bin_watch = {5'd13, 6'd20, 6'd30}; then IDLE, editing = 0.
- Wrap checks:
  - Hour 23 + up -> 0.
  - btn_next, min 0 + down -> 59.
  - btn_next, sec 59 + up -> 0; commit -> bin_watch = {0, 59, 0}.
- Priority: btn_mode and btn_up in the same EDIT_HOUR cycle -> COMMIT with hour unchanged.
- Up and down together -> field unchanged.
- Timeout with TIMEOUT_S = 3:
  - Enter edit, apply 3 en_1hz ticks with no buttons -> IDLE, set_watch never asserted.
  - A btn_next after 2 ticks restarts the count.
- Frozen shadow: en_1hz ticks during edit leave bin_watch at the captured value.
- Reset and capture clamp:
  - rst high while in EDIT_SEC -> next cycle IDLE, all outputs 0, no set_watch.
  - cur_min = 62 at capture -> shadow min = 0.
